// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared widths and enums for the two-port SRAM arbiter
package mem_arb_pkg;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    typedef enum logic {
        OWN_FETCH,
        OWN_LSU
    } owner_t;
endpackage

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - 2-way round-robin picker between fetch and load/store requests
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic   f_req,
    input  logic   l_req,
    input  owner_t last_owner,
    output logic   grant_valid,
    output owner_t grant_id
);

    always_comb begin
        grant_valid = f_req | l_req;
        grant_id    = OWN_FETCH;
        // On a tie the port that was not served last wins.
        if (f_req && l_req) begin
            grant_id = (last_owner == OWN_FETCH) ? OWN_LSU : OWN_FETCH;
        end else if (l_req) begin
            grant_id = OWN_LSU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates fetch and load/store ports onto one SRAM with response timeout
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_done,
    output logic              f_err,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_done,
    output logic              l_err,
    output logic [DATA_W-1:0] l_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] mem_data,
    input  logic              mem_resp,
    output logic              busy
);

    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

    state_t            state;
    owner_t            owner;
    owner_t            last_owner;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        cnt;
    logic              grant_valid;
    owner_t            grant_id;

    mem_arb_rr u_rr (
        .f_req       (f_req),
        .l_req       (l_req),
        .last_owner  (last_owner),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign mem_addr = addr_q;
    // mem_we is only ever high in BUSY for a store, so it doubles as the bus enable.
    assign mem_data = mem_we ? wdata_q : 'z;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            owner      <= OWN_FETCH;
            last_owner <= OWN_FETCH;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt        <= '0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            busy       <= 1'b0;
            f_done     <= 1'b0;
            f_err      <= 1'b0;
            f_rdata    <= '0;
            l_done     <= 1'b0;
            l_err      <= 1'b0;
            l_rdata    <= '0;
        end else begin
            f_done <= 1'b0;
            l_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_valid) begin
                        state      <= S_BUSY;
                        busy       <= 1'b1;
                        owner      <= grant_id;
                        last_owner <= grant_id;
                        cnt        <= '0;
                        if (grant_id == OWN_LSU) begin
                            we_q    <= l_we;
                            addr_q  <= l_addr;
                            wdata_q <= l_wdata;
                            mem_re  <= !l_we;
                            mem_we  <= l_we;
                        end else begin
                            we_q    <= 1'b0;
                            addr_q  <= f_addr;
                            mem_re  <= 1'b1;
                            mem_we  <= 1'b0;
                        end
                    end
                end
                S_BUSY: begin
                    // A response arriving on the timeout cycle still counts as success.
                    if (mem_resp || cnt == TIMEOUT_M1) begin
                        state  <= S_DONE;
                        mem_re <= 1'b0;
                        mem_we <= 1'b0;
                        if (owner == OWN_FETCH) begin
                            f_done <= 1'b1;
                            f_err  <= !mem_resp;
                            if (!mem_resp) begin
                                f_rdata <= '0;
                            end else if (!we_q) begin
                                f_rdata <= mem_data;
                            end
                        end else begin
                            l_done <= 1'b1;
                            l_err  <= !mem_resp;
                            if (!mem_resp) begin
                                l_rdata <= '0;
                            end else if (!we_q) begin
                                l_rdata <= mem_data;
                            end
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15 (legal 1..255): max BUSY cycles waiting for mem_resp before abort.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 f_req  input  1  fetch requester read request; held high until f_done.
REQ-005 f_addr  input  14  fetch word address.
REQ-006 f_done / f_err  output  1 each  one-cycle completion pulse / timeout flag, valid with f_done.
REQ-007 f_rdata  output  16  fetch read data, valid with f_done.
REQ-008 l_req  input  1  load/store requester request; held high until l_done.
REQ-009 l_we  input  1  1 = store, 0 = load.
REQ-010 l_addr  input  14  load/store word address.
REQ-011 l_wdata  input  16  store data.
REQ-012 l_done / l_err  output  1 each  completion pulse / timeout flag, valid with l_done.
REQ-013 l_rdata  output  16  load read data, valid with l_done.
REQ-014 mem_re / mem_we  output  1 each  SRAM read / write enable.
REQ-015 mem_addr  output  14  SRAM address.
REQ-016 mem_data  inout  16  SRAM bidirectional data bus.
REQ-017 mem_resp  input  1  SRAM completion strobe.
REQ-018 busy  output  1  high in any non-IDLE state.

Function
REQ-019 FSM states IDLE, BUSY, DONE; owner register (FETCH/LSU); round-robin pointer last_owner.
REQ-020 IDLE: single req -> grant that port; both req -> grant port != last_owner; next state BUSY.
REQ-021 On grant edge: latch owner, addr, we (fetch: we=0), wdata; update last_owner; zero timeout counter.
REQ-022 BUSY: mem_re = !we_q, mem_we = we_q, mem_addr = addr_q; all held constant until exit; requester inputs ignored.
REQ-023 mem_data driven with wdata_q only in BUSY with we_q=1; high-Z otherwise.
REQ-024 BUSY with mem_resp=1 -> DONE; read data sampled from mem_data that edge into owner's rdata register, err=0.
REQ-025 BUSY, counter reaches TIMEOUT with no mem_resp -> DONE, err=1, rdata=0x0000.
REQ-026 Simultaneous mem_resp and timeout in same cycle: mem_resp wins, err=0.
REQ-027 DONE: owner's done high exactly one cycle, err as latched; mem_re/mem_we low; requests ignored; next state IDLE.
REQ-028 Store completion: done pulse, rdata unchanged from previous value.
REQ-029 mem_resp outside BUSY ignored.
REQ-030 Latency with idle SRAM: req seen cycle N -> enables high N+1 -> done = cycle after mem_resp.
REQ-031 Non-owner rdata/err/done unchanged throughout another port's transaction.

Reset
REQ-032 Reset high: state IDLE, last_owner=FETCH (LSU wins first tie), counter 0, all done/err/mem_re/mem_we/busy 0, rdata 0, mem_data high-Z.
REQ-033 Reset mid-BUSY: enables drop at next edge, no done pulse issued, transaction abandoned.

Structure
REQ-034 Package mem_arb_pkg: ADDR_W=14, DATA_W=16, state enum, owner enum.
REQ-035 One sub-module, mem_arb_rr: 2-way round-robin picker (reqs, last_owner -> grant valid, grant id).

Verification
REQ-036 Fetch only: f_addr=0x0010, mem_resp two cycles after mem_re with data 0xBEEF -> f_rdata=0xBEEF, f_done one cycle, f_err=0.
REQ-037 Simultaneous f_req/l_req after reset -> LSU first, fetch second; repeated ties alternate.
REQ-038 Store l_addr=0x3FFF, l_wdata=0xA5A5 -> mem_we=1, mem_data=0xA5A5 until mem_resp; later load returns 0xA5A5.
REQ-039 TIMEOUT=4, no mem_resp -> l_done+l_err after 4 BUSY cycles, l_rdata=0; mem_resp on 4th cycle -> err=0.
REQ-040 Reset asserted mid-BUSY -> enables 0 next edge, no done, next request served normally.
